// File: rtl/tpu_pkg.sv
// Shared TPU definitions: accumulator geometry, sequencer state encoding and the
// address-width helper used to size the accumulator ports.
package tpu_pkg;

  // Bits needed to represent value (clogb2(63) = 6).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return r;
  endfunction

  localparam int ACC_RAM_DEPTH  = 64;
  localparam int ACC_ADDR_WIDTH = clogb2(ACC_RAM_DEPTH - 1);
  localparam int ACC_KT_WIDTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } acc_state_e;

endpackage

// File: rtl/acc_drain_ctrl.sv
// Drain side of the accumulator sequencer: issues RAM reads and tracks the
// registered row held on doutb against downstream backpressure.
module acc_drain_ctrl
  import tpu_pkg::*;
#(
  parameter int ADDR_WIDTH = ACC_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [ADDR_WIDTH:0]   rows,
  input  logic                  out_ready,
  output logic                  acc_enb,
  output logic [ADDR_WIDTH-1:0] acc_addrb,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  drain_done
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          issue;

  // A read may be issued only when doutb is free or being consumed this cycle,
  // so a stalled row is never overwritten.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    issue   = 1'b0;
    rd_cnt_d = '0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    if (en) begin
      issue    = (rd_cnt_q < rows) && (!valid_q || out_ready);
      rd_cnt_d = rd_cnt_q + CW'(issue);
      valid_d  = issue || (valid_q && !out_ready);
      if (issue) begin
        last_d = (rd_cnt_q == rows - CW'(1));
      end else if (valid_q && !out_ready) begin
        last_d = last_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  assign acc_enb    = issue;
  assign acc_addrb  = rd_cnt_q[ADDR_WIDTH-1:0];
  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign drain_done = valid_q && out_ready && last_q;

endmodule

// File: rtl/acc_seq_ctrl.sv
// Accumulator RAM sequencer for one output tile: overwrite/accumulate writes over
// cfg_ktiles K-tiles, then a backpressured drain of cfg_rows rows.
module acc_seq_ctrl
  import tpu_pkg::*;
#(
  parameter int RAM_DEPTH  = ACC_RAM_DEPTH,
  parameter int ADDR_WIDTH = clogb2(RAM_DEPTH - 1),
  parameter int KT_WIDTH   = ACC_KT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   cfg_rows,
  input  logic [KT_WIDTH-1:0]   cfg_ktiles,
  input  logic                  sa_valid,
  output logic                  acc_wea,
  output logic [ADDR_WIDTH-1:0] acc_addra,
  output logic                  acc_en,
  output logic                  acc_enb,
  output logic [ADDR_WIDTH-1:0] acc_addrb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = ADDR_WIDTH + 1;

  acc_state_e            state_q;
  logic [CW-1:0]         cfg_rows_q, row_cnt_q;
  logic [KT_WIDTH-1:0]   cfg_ktiles_q, kt_cnt_q;
  logic                  done_q, busy_q;
  logic                  in_accum, row_last, kt_last, drain_done;

  assign in_accum = (state_q == ST_ACCUM);
  assign row_last = (row_cnt_q == cfg_rows_q - CW'(1));
  assign kt_last  = (kt_cnt_q == cfg_ktiles_q - KT_WIDTH'(1));

  // Write port follows sa_valid in the same cycle; the RAM does its own RMW.
  assign acc_wea   = in_accum && sa_valid;
  assign acc_addra = in_accum ? row_cnt_q[ADDR_WIDTH-1:0] : '0;
  assign acc_en    = in_accum && (kt_cnt_q != '0);
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      state_q      <= ST_IDLE;
      cfg_rows_q   <= '0;
      cfg_ktiles_q <= '0;
      row_cnt_q    <= '0;
      kt_cnt_q     <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cfg_rows_q   <= cfg_rows;
            cfg_ktiles_q <= cfg_ktiles;
            row_cnt_q    <= '0;
            kt_cnt_q     <= '0;
            busy_q       <= 1'b1;
            if (cfg_rows == '0 || cfg_ktiles == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (sa_valid) begin
            if (row_last) begin
              row_cnt_q <= '0;
              kt_cnt_q  <= kt_cnt_q + KT_WIDTH'(1);
              if (kt_last) begin
                state_q <= ST_DRAIN;
              end
            end else begin
              row_cnt_q <= row_cnt_q + CW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  acc_drain_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_drain (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q == ST_DRAIN),
    .rows      (cfg_rows_q),
    .out_ready (out_ready),
    .acc_enb   (acc_enb),
    .acc_addrb (acc_addrb),
    .out_valid (out_valid),
    .out_last  (out_last),
    .drain_done(drain_done)
  );

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed bench for acc_seq_ctrl with a behavioural accumulator RAM (one int per row)
// and hand-computed expected addresses, timings and drained sums.
module tb_acc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, sa_valid, out_ready;
  logic [6:0] cfg_rows;
  logic [7:0] cfg_ktiles;
  logic       acc_wea, acc_en, acc_enb, out_valid, out_last, busy, done;
  logic [5:0] acc_addra, acc_addrb;

  int sa_data;
  int ram [64];
  int doutb;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  int wa_addr[$], wa_en[$], wa_cyc[$];
  int bt_data[$], bt_last[$], bt_cyc[$];
  int dn_cyc[$];
  int enb_cnt = 0;

  acc_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_ktiles(cfg_ktiles),
    .sa_valid(sa_valid), .acc_wea(acc_wea), .acc_addra(acc_addra), .acc_en(acc_en),
    .acc_enb(acc_enb), .acc_addrb(acc_addrb), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (acc_wea) ram[acc_addra] <= acc_en ? ram[acc_addra] + sa_data : sa_data;
    if (acc_enb) doutb <= ram[acc_addrb];
  end

  always @(negedge clk) begin
    if (acc_wea) begin
      wa_addr.push_back(int'(acc_addra));
      wa_en.push_back(int'(acc_en));
      wa_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      bt_data.push_back(doutb);
      bt_last.push_back(int'(out_last));
      bt_cyc.push_back(cyc);
    end
    if (done) dn_cyc.push_back(cyc);
    if (acc_enb) enb_cnt <= enb_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wa_addr.delete(); wa_en.delete(); wa_cyc.delete();
    bt_data.delete(); bt_last.delete(); bt_cyc.delete();
    dn_cyc.delete();
    enb_cnt = 0;
  endtask

  task automatic start_tile(input int rows, input int kt, output int ts);
    start = 1'b1;
    cfg_rows = 7'(rows);
    cfg_ktiles = 8'(kt);
    ts = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic feed_one(input int d, input int gap);
    sa_valid = 1'b1;
    sa_data = d;
    tick();
    sa_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n0;
    int k;
    n0 = dn_cyc.size();
    k = 0;
    while (dn_cyc.size() == n0 && k < limit) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, 32'(dn_cyc.size() > n0), 1);
  endtask

  initial begin
    int ts;
    int k;
    rst = 1'b1; start = 1'b0; sa_valid = 1'b0; out_ready = 1'b1;
    cfg_rows = '0; cfg_ktiles = '0; sa_data = 0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wea", acc_wea, 0);
    check("rst_enb", acc_enb, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_addra", acc_addra, 0);
    check("rst_addrb", acc_addrb, 0);
    rst = 1'b0;
    tick();

    // sa_valid in IDLE must not write
    sa_valid = 1'b1;
    #1;
    check("idle_wea", acc_wea, 0);
    tick();
    sa_valid = 1'b0;

    // 1: rows=4, ktiles=1, consecutive writes, free-running drain
    clear_logs();
    start_tile(4, 1, ts);
    for (int i = 0; i < 4; i++) feed_one(10 * (i + 1), 0);
    wait_done("t1", 40);
    check("t1_busy_after", busy, 0);
    check("t1_wr_n", wa_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_addra", qget(wa_addr, i), i);
      check("t1_en", qget(wa_en, i), 0);
    end
    check("t1_first_wea_lat", qget(wa_cyc, 0) - ts, 1);
    check("t1_beats", bt_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_data", qget(bt_data, i), 10 * (i + 1));
      check("t1_last", qget(bt_last, i), (i == 3) ? 1 : 0);
    end
    check("t1_first_valid_lat", qget(bt_cyc, 0) - qget(wa_cyc, 3), 2);
    check("t1_stream", qget(bt_cyc, 3) - qget(bt_cyc, 0), 3);
    check("t1_done_lat", qget(dn_cyc, 0) - qget(bt_cyc, 3), 1);
    check("t1_done_n", dn_cyc.size(), 1);

    // 2: rows=2, ktiles=3 with 1-cycle gaps; sums of three K-tiles
    clear_logs();
    start_tile(2, 3, ts);
    feed_one(1, 1);    feed_one(2, 1);
    feed_one(100, 1);  feed_one(200, 1);
    feed_one(1000, 1); feed_one(2000, 1);
    wait_done("t2", 40);
    check("t2_wr_n", wa_addr.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("t2_addra", qget(wa_addr, i), i % 2);
      check("t2_en", qget(wa_en, i), (i < 2) ? 0 : 1);
    end
    check("t2_beats", bt_data.size(), 2);
    check("t2_row0", qget(bt_data, 0), 1101);
    check("t2_row1", qget(bt_data, 1), 2202);

    // 3: backpressure, 3-cycle stall on the first beat
    clear_logs();
    out_ready = 1'b0;
    start_tile(4, 1, ts);
    for (int i = 0; i < 4; i++) feed_one(5 + i, 0);
    k = 0;
    while (!out_valid && k < 10) begin
      tick();
      k++;
    end
    check("t3_valid_seen", out_valid, 1);
    for (int s = 0; s < 3; s++) begin
      check("t3_stall_enb", acc_enb, 0);
      check("t3_stall_valid", out_valid, 1);
      check("t3_stall_dout", doutb, 5);
      if (s < 2) tick();
    end
    out_ready = 1'b1;
    wait_done("t3", 40);
    check("t3_beats", bt_data.size(), 4);
    for (int i = 0; i < 4; i++) check("t3_data", qget(bt_data, i), 5 + i);
    check("t3_reads", enb_cnt, 4);
    check("t3_last", qget(bt_last, 3), 1);

    // 4: zero-size tiles finish without touching the RAM
    clear_logs();
    start_tile(0, 5, ts);
    wait_done("t4a", 10);
    k = qget(dn_cyc, 0) - ts;
    check("t4a_done_lat", 32'(k >= 1 && k <= 2), 1);
    tick();
    start_tile(3, 0, ts);
    wait_done("t4b", 10);
    tick();
    check("t4_done_n", dn_cyc.size(), 2);
    check("t4_wea_n", wa_addr.size(), 0);
    check("t4_enb_n", enb_cnt, 0);
    check("t4_busy", busy, 0);

    // 5: reset mid-ACCUM aborts, then a clean tile
    start_tile(8, 1, ts);
    for (int i = 0; i < 3; i++) feed_one(50 + i, 0);
    check("t5_busy_pre", busy, 1);
    sa_valid = 1'b1;
    rst = 1'b1;
    tick();
    check("t5_busy", busy, 0);
    check("t5_wea", acc_wea, 0);
    check("t5_enb", acc_enb, 0);
    check("t5_valid", out_valid, 0);
    check("t5_done", done, 0);
    check("t5_addra", acc_addra, 0);
    rst = 1'b0;
    sa_valid = 1'b0;
    tick();
    clear_logs();
    start_tile(2, 1, ts);
    feed_one(77, 0);
    feed_one(88, 0);
    wait_done("t5", 30);
    check("t5_wr_n", wa_addr.size(), 2);
    check("t5_en0", qget(wa_en, 0), 0);
    check("t5_en1", qget(wa_en, 1), 0);
    check("t5_addr1", qget(wa_addr, 1), 1);
    check("t5_row0", qget(bt_data, 0), 77);
    check("t5_row1", qget(bt_data, 1), 88);

    // 6: full-depth tile, two K-tiles, stray start mid-ACCUM
    clear_logs();
    start_tile(64, 2, ts);
    for (int i = 0; i < 128; i++) begin
      if (i == 10) begin
        start = 1'b1;
        cfg_rows = 7'd3;
        cfg_ktiles = 8'd1;
      end
      feed_one((i < 64) ? i : 1000 + (i - 64), 0);
      start = 1'b0;
    end
    wait_done("t6", 300);
    check("t6_wr_n", wa_addr.size(), 128);
    check("t6_addr63", qget(wa_addr, 63), 63);
    check("t6_addr64", qget(wa_addr, 64), 0);
    check("t6_addr127", qget(wa_addr, 127), 63);
    check("t6_en63", qget(wa_en, 63), 0);
    check("t6_en64", qget(wa_en, 64), 1);
    check("t6_beats", bt_data.size(), 64);
    for (int r = 0; r < 64; r++) check("t6_data", qget(bt_data, r), 1000 + 2 * r);
    k = 0;
    foreach (bt_last[i]) k += bt_last[i];
    check("t6_last_n", k, 1);
    check("t6_last63", qget(bt_last, 63), 1);
    check("t6_done_n", dn_cyc.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
